// File: rtl/cpu_pio_out_pkg.sv
// Shared register map and STATUS field layout for the output PIO with blink support.
package cpu_pio_out_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN  = 3'd1;
    localparam logic [2:0] ADDR_PERIOD    = 3'd2;
    localparam logic [2:0] ADDR_STATUS    = 3'd3;
    localparam logic [2:0] ADDR_OUTSET    = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
    localparam logic [2:0] ADDR_OUTTOGGLE = 3'd6;

    localparam int STATUS_PHASE_BIT  = 0;
    localparam int STATUS_COUNT_LSB  = 1;
    localparam int STATUS_COUNT_BITS = 31;

endpackage

// File: rtl/cpu_pio_blink_timer.sv
// Blink prescaler: each phase half-period lasts period+1 clocks; period==0 parks phase high.
module cpu_pio_blink_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] period,
    input  logic             load,
    output logic             phase,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            phase <= 1'b1;
        end else if (load) begin
            // A PERIOD write restarts the blink high and wins over any tick in this cycle.
            count <= period;
            phase <= 1'b1;
        end else if (period == '0) begin
            count <= '0;
            phase <= 1'b1;
        end else if (count == '0) begin
            count <= period;
            phase <= ~phase;
        end else begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_pio_out_gen.sv
// Avalon-MM output PIO with atomic set/clear/toggle writes and per-bit hardware blink.
module cpu_pio_out_gen
    import cpu_pio_out_pkg::*;
#(
    parameter int               WIDTH       = 7,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               CNT_W       = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("cpu_pio_out_gen: WIDTH must be in 1..32");
        end
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("cpu_pio_out_gen: CNT_W must be in 1..32");
        end
    endgenerate

    logic             wr_en;
    logic             period_load;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] blink_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] period_next;
    logic [CNT_W-1:0] count;
    logic [31:0]      count_ext;
    logic             phase;
    logic             unused_bits;

    assign wr_en       = chipselect && !write_n;
    assign wd          = writedata[WIDTH-1:0];
    assign period_load = wr_en && (address == ADDR_PERIOD);
    // The timer sees the incoming value on the load cycle so count starts from the new period.
    assign period_next = period_load ? writedata[CNT_W-1:0] : period_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q   <= RESET_VALUE;
            blink_q  <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:      data_q   <= wd;
                ADDR_BLINK_EN:  blink_q  <= wd;
                ADDR_PERIOD:    period_q <= writedata[CNT_W-1:0];
                ADDR_OUTSET:    data_q   <= data_q | wd;
                ADDR_OUTCLEAR:  data_q   <= data_q & ~wd;
                ADDR_OUTTOGGLE: data_q   <= data_q ^ wd;
                default: ;
            endcase
        end
    end

    cpu_pio_blink_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_next),
        .load    (period_load),
        .phase   (phase),
        .count   (count)
    );

    assign out_port = data_q & (~blink_q | {WIDTH{phase}});

    always_comb begin
        count_ext             = '0;
        count_ext[CNT_W-1:0]  = count;
    end

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = data_q;
            ADDR_BLINK_EN: readdata[WIDTH-1:0] = blink_q;
            ADDR_PERIOD:   readdata[CNT_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = phase;
                readdata[STATUS_COUNT_LSB +: STATUS_COUNT_BITS] = count_ext[STATUS_COUNT_BITS-1:0];
            end
            default: ;
        endcase
    end

    assign unused_bits = &{1'b0, writedata, count_ext[31]};

endmodule

// File: tb/tb_cpu_pio_out_gen.sv
// Self-checking bench: directed tables, blink sequences and random traffic against a timing model.
module tb_cpu_pio_out_gen;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [2:0]  address = 3'd0;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata, rd32, rd3;
    logic [6:0]  out_port;
    logic [31:0] op32;
    logic [2:0]  op3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents plus edges elapsed since the last PERIOD load.
    logic [6:0]  m_data, m_blink;
    logic [23:0] m_period;
    int          m_n;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [6:0]  exp_data;
        logic [6:0]  exp_out;
    } vec_t;

    vec_t vecs[4];

    cpu_pio_out_gen #(.WIDTH(7), .RESET_VALUE(7'h55), .CNT_W(24)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    cpu_pio_out_gen #(.WIDTH(32), .RESET_VALUE(32'h0), .CNT_W(32)) dut_w32 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd32), .out_port(op32)
    );

    cpu_pio_out_gen #(.WIDTH(3), .RESET_VALUE(3'h0), .CNT_W(4)) dut_w3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd3), .out_port(op3)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic m_phase();
        if (m_period == 24'd0) return 1'b1;
        return ((m_n / (int'(m_period) + 1)) % 2) == 0;
    endfunction

    function automatic logic [23:0] m_count();
        if (m_period == 24'd0) return 24'd0;
        return m_period - 24'(m_n % (int'(m_period) + 1));
    endfunction

    function automatic logic [6:0] m_out();
        return m_data & (~m_blink | {7{m_phase()}});
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {25'd0, m_data};
            3'd1:    return {25'd0, m_blink};
            3'd2:    return {8'd0, m_period};
            3'd3:    return {7'd0, m_count(), m_phase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_data   = 7'h55;
        m_blink  = 7'h00;
        m_period = 24'd0;
        m_n      = 0;
    endtask

    // Called at a negedge: drives one bus cycle, updates the model on the edge, returns at the next negedge.
    task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        if (cs && !wn) begin
            case (a)
                3'd0: m_data   = wd[6:0];
                3'd1: m_blink  = wd[6:0];
                3'd2: m_period = wd[23:0];
                3'd4: m_data   = m_data | wd[6:0];
                3'd5: m_data   = m_data & ~wd[6:0];
                3'd6: m_data   = m_data ^ wd[6:0];
                default: ;
            endcase
        end
        if (cs && !wn && a == 3'd2) m_n = 0;
        else                        m_n++;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        step(1'b1, 1'b0, a, wd);
    endtask

    task automatic idle();
        step(1'b0, 1'b1, 3'd0, 32'd0);
    endtask

    task automatic check_read(input string name, input logic [2:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    initial begin
        vecs[0] = '{3'd0, 32'h0000_000F, 7'h0F, 7'h0F};
        vecs[1] = '{3'd4, 32'hFFFF_FF30, 7'h3F, 7'h3F};
        vecs[2] = '{3'd5, 32'h0000_0003, 7'h3C, 7'h3C};
        vecs[3] = '{3'd6, 32'h0000_0041, 7'h7D, 7'h7D};

        m_reset();
        repeat (3) @(negedge clk);
        check("reset_out_in_reset", {25'd0, out_port}, 32'h55);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_out", {25'd0, out_port}, 32'h55);
        check_read("reset_data", 3'd0, 32'h55);
        check_read("reset_blink", 3'd1, 32'h0);
        check_read("reset_period", 3'd2, 32'h0);
        check_read("reset_status", 3'd3, 32'h1);
        check_read("reset_rsvd", 3'd7, 32'h0);

        // Atomic DATA updates.
        for (int i = 0; i < 4; i++) begin
            wr(vecs[i].addr, vecs[i].wd);
            check($sformatf("vec%0d_out", i), {25'd0, out_port}, {25'd0, vecs[i].exp_out});
            check_read($sformatf("vec%0d_data", i), 3'd0, {25'd0, vecs[i].exp_data});
        end
        check_read("wo_outset_reads_0", 3'd4, 32'h0);
        check_read("wo_toggle_reads_0", 3'd6, 32'h0);

        // Width boundaries: all three builds see the same write.
        wr(3'd0, 32'hFFFF_FFFF);
        m_data = 7'h7F;
        address = 3'd0;
        #1;
        check("w32_data", rd32, 32'hFFFF_FFFF);
        check("w3_data", rd3, 32'h7);
        check("w7_data", readdata, 32'h7F);
        check("w32_out", op32, 32'hFFFF_FFFF);
        check("w3_out", {29'd0, op3}, 32'h7);
        wr(3'd7, 32'h0);
        wr(3'd3, 32'hFFFF_FFFF);
        check_read("status_write_ignored", 3'd3, 32'h1);

        // Blink bit 0 with PERIOD=3: four clocks high, four low.
        wr(3'd0, 32'h7F);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'd3);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("blink3_b0_%0d", i), {31'd0, out_port[0]}, {31'd0, ((i / 4) % 2) == 0});
            check("blink3_upper", {26'd0, out_port[6:1]}, 32'h3F);
            address = 3'd3;
            #1;
            check("blink3_status_phase", {31'd0, readdata[0]}, {31'd0, ((i / 4) % 2) == 0});
            idle();
        end

        // PERIOD=0 mid-low-phase parks the output high.
        repeat (5) idle();
        check("blink3_low_before_stop", {31'd0, out_port[0]}, 32'd0);
        wr(3'd2, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("period0_steady", {25'd0, out_port}, 32'h7F);
            idle();
        end

        // PERIOD=1: two-clock half-periods, starting high.
        wr(3'd2, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("blink1_b0_%0d", i), {31'd0, out_port[0]}, {31'd0, ((i / 2) % 2) == 0});
            idle();
        end

        // OUTTOGGLE on the same edge as a phase tick.
        idle();
        check_read("tick_pending_status", 3'd3, 32'h1);
        wr(3'd6, 32'h40);
        check("toggle_tick_out", {25'd0, out_port}, 32'h3E);
        check_read("toggle_tick_data", 3'd0, 32'h3F);
        check_read("toggle_tick_status", 3'd3, 32'h2);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [2:0]  ra;
            logic        cs, wn;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = 1'($urandom_range(0, 1));
            wd = $urandom;
            if (a == 3'd2) wd = (($urandom_range(0, 9) == 0) ? 32'h00FF_0000 : 32'($urandom_range(0, 6))) | 32'hFF00_0000;
            step(cs, wn, a, wd);
            check("rand_out", {25'd0, out_port}, {25'd0, m_out()});
            ra = 3'($urandom_range(0, 7));
            check_read($sformatf("rand_rd_a%0d", ra), ra, m_read(ra));
        end

        // Asynchronous reset in the low half of a blink.
        wr(3'd0, 32'h7F);
        wr(3'd1, 32'h7F);
        wr(3'd2, 32'd2);
        repeat (3) idle();
        check("pre_reset_low", {25'd0, out_port}, 32'h0);
        #10;
        reset_n = 1'b0;
        #1;
        check("async_reset_out", {25'd0, out_port}, 32'h55);
        @(negedge clk);
        reset_n = 1'b1;
        m_reset();
        @(negedge clk);
        check_read("post_reset_blink", 3'd1, 32'h0);
        check_read("post_reset_period", 3'd2, 32'h0);
        check_read("post_reset_status", 3'd3, 32'h1);
        check("post_reset_out", {25'd0, out_port}, 32'h55);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
